// File: rtl/cva6_thread_scheduler_if.sv
// Control/frontend bundle of the hardware-thread scheduler.
// The master side (CSR/control unit together with the frontend) drives the
// thread status and the frontend handshake. The slave side (the scheduler)
// returns the selected thread.
interface cva6_thread_scheduler_if #(
    parameter int NUM_THREADS     = 2,
    parameter int NUM_THREADS_LOG = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int QUANTUM_W       = 8
);
    logic [NUM_THREADS-1:0]     thread_en_i;
    logic [NUM_THREADS-1:0]     thread_stall_i;
    logic [1:0]                 mode_i;
    logic [QUANTUM_W-1:0]       quantum_i;
    logic                       advance_i;
    logic                       flush_i;
    logic [NUM_THREADS_LOG-1:0] tid_o;
    logic                       tid_valid_o;
    logic                       switch_o;

    modport master (
        output thread_en_i, thread_stall_i, mode_i, quantum_i, advance_i, flush_i,
        input  tid_o, tid_valid_o, switch_o
    );

    modport slave (
        input  thread_en_i, thread_stall_i, mode_i, quantum_i, advance_i, flush_i,
        output tid_o, tid_valid_o, switch_o
    );
endinterface

// File: rtl/cva6_thread_scheduler.sv
// Per-cycle hardware-thread selector for the multithreaded CVA6 frontend.
// It supports three modes: round-robin, coarse-grained (quantum/stall switch)
// and fixed priority. All outputs are registered.
// Optional macro CVA6_THREAD_STATS_EN: when it is defined, the design adds
// per-thread issue counters and a switch counter as extra output ports.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no thread selected (after reset, flush or all ineligible)
// ST_RUN  | tid_o holds an eligible thread the frontend may fetch
module cva6_thread_scheduler #(
    parameter int NUM_THREADS     = 2,
    parameter int NUM_THREADS_LOG = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int QUANTUM_W       = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    cva6_thread_scheduler_if.slave        sched_if
`ifdef CVA6_THREAD_STATS_EN
    ,
    output logic [NUM_THREADS*32-1:0]     stat_issue_o,
    output logic [31:0]                   stat_switch_o
`endif
);

    localparam int TW = NUM_THREADS_LOG;

    localparam logic [1:0] MODE_COARSE = 2'd1;
    localparam logic [1:0] MODE_PRIO   = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TW-1:0]        r_tid;
    logic [TW-1:0]        w_tid_nxt;
    logic                 r_switch;
    logic                 w_switch_nxt;
    logic [QUANTUM_W-1:0] r_count;
    logic [QUANTUM_W-1:0] w_count_nxt;
    logic [1:0]           r_mode_q;
    logic [NUM_THREADS-1:0] w_elig;
    logic                 w_any_elig;
    logic                 w_cur_elig;
    logic [TW-1:0]        w_next_after;
    logic [TW-1:0]        w_lowest;
    logic                 w_quantum_hit;

    // First eligible thread after cur, wrapping around; cur itself comes last.
    // Descending k, so the smallest distance is assigned last and wins.
    function automatic logic [TW-1:0] f_next_after(input logic [TW-1:0] cur,
                                                   input logic [NUM_THREADS-1:0] elig);
        logic [TW-1:0] sel;
        logic [TW-1:0] idx;
        int            pos;
        sel = cur;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            pos = int'(cur) + k;
            if (pos >= NUM_THREADS) begin
                pos = pos - NUM_THREADS;
            end
            idx = pos[TW-1:0];
            if (elig[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    // The lowest-numbered eligible thread; 0 when no thread is eligible.
    function automatic logic [TW-1:0] f_lowest(input logic [NUM_THREADS-1:0] elig);
        logic [TW-1:0] sel;
        logic [TW-1:0] idx;
        sel = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            idx = i[TW-1:0];
            if (elig[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    assign w_elig        = sched_if.thread_en_i & ~sched_if.thread_stall_i;
    assign w_any_elig    = |w_elig;
    assign w_cur_elig    = w_elig[r_tid];
    assign w_next_after  = f_next_after(r_tid, w_elig);
    assign w_lowest      = f_lowest(w_elig);
    // A compare against quantum-1 using >= also covers a quantum that is
    // lowered mid-run below the current count: the switch comes at the next advance.
    assign w_quantum_hit = (sched_if.quantum_i != '0) &&
                           (r_count >= (sched_if.quantum_i - QUANTUM_W'(1)));

    // Register the state, tid, switch pulse, quantum count and last-seen mode.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_tid    <= '0;
            r_switch <= 1'b0;
            r_count  <= '0;
            r_mode_q <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_tid    <= w_tid_nxt;
            r_switch <= w_switch_nxt;
            r_count  <= w_count_nxt;
            r_mode_q <= sched_if.mode_i;
        end
    end

    // Choose the next thread; the checks run in priority order, highest first.
    always_comb begin
        w_state_nxt = r_state;
        w_tid_nxt   = r_tid;
        w_count_nxt = r_count;

        if (NUM_THREADS == 1) begin
            w_tid_nxt   = '0;
            w_count_nxt = '0;
            w_state_nxt = w_elig[0] ? ST_RUN : ST_IDLE;
        end else if (sched_if.flush_i) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else if (!w_any_elig) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_RUN;
            w_tid_nxt   = w_next_after;
            w_count_nxt = '0;
        end else if (!w_cur_elig) begin
            w_tid_nxt   = w_next_after;
            w_count_nxt = '0;
        end else begin
            case (sched_if.mode_i)
                MODE_PRIO: begin
                    w_tid_nxt   = w_lowest;
                    w_count_nxt = '0;
                end
                MODE_COARSE: begin
                    if (sched_if.advance_i) begin
                        if (w_quantum_hit) begin
                            w_tid_nxt   = w_next_after;
                            w_count_nxt = '0;
                        end else begin
                            w_count_nxt = r_count + QUANTUM_W'(1);
                        end
                    end
                end
                default: begin
                    // Mode 3 is reserved and behaves the same as round-robin.
                    if (sched_if.advance_i) begin
                        w_tid_nxt = w_next_after;
                    end
                end
            endcase
        end

        // A new mode always starts with a fresh quantum.
        if (sched_if.mode_i != r_mode_q) begin
            w_count_nxt = '0;
        end

        w_switch_nxt = (w_state_nxt == ST_RUN) &&
                       ((w_tid_nxt != r_tid) || (r_state != ST_RUN));
    end

    assign sched_if.tid_o       = r_tid;
    assign sched_if.tid_valid_o = (r_state == ST_RUN);
    assign sched_if.switch_o    = r_switch;

`ifdef CVA6_THREAD_STATS_EN
    logic [NUM_THREADS-1:0][31:0] r_stat_issue;
    logic [31:0]                  r_stat_switch;

    // Credit each advance to the thread it was issued for, and count switch pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stat_issue  <= '0;
            r_stat_switch <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (sched_if.advance_i && (r_state == ST_RUN) && (r_tid == i[TW-1:0])) begin
                    r_stat_issue[i] <= r_stat_issue[i] + 32'd1;
                end
            end
            if (r_switch) begin
                r_stat_switch <= r_stat_switch + 32'd1;
            end
        end
    end

    assign stat_issue_o  = r_stat_issue;
    assign stat_switch_o = r_stat_switch;
`endif

endmodule
